// File: rtl/parity_frame_ctrl.sv
// Frame-level parity controller: serialises accepted words LSB-first into a
// running parity, checks it against the expected parity on the last word, and reports per frame.
module parity_frame_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_exp_par,
  output logic              cur_odd,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_err,
  output logic              res_parity,
  output logic [7:0]        res_words,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned WCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK,
    REPORT
  } state_t;

  state_t state;
  state_t next_state;

  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              last_q;
  logic              exp_q;
  logic              frame_open;
  logic              parity;
  logic [WCNT_W-1:0] word_cnt;

  logic accept;
  logic shift_en;
  logic check_en;
  logic res_done;
  logic shift_end;
  logic frame_err;

  assign cur_odd   = parity;
  assign frame_err = parity ^ exp_q;

  // Next-state and per-cycle control strobes
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    shift_en   = 1'b0;
    check_en   = 1'b0;
    res_done   = 1'b0;
    shift_end  = (bit_cnt == BIT_W'(DATA_W - 1));
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (shift_end) begin
          next_state = last_q ? CHECK : IDLE;
        end
      end
      CHECK: begin
        check_en   = 1'b1;
        next_state = REPORT;
      end
      REPORT: begin
        if (res_ready) begin
          res_done   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Handshake flags decoded from the next state so they are valid from flops
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
    end else begin
      in_ready  <= (next_state == IDLE);
      res_valid <= (next_state == REPORT);
    end
  end

  // Word load, bit-serial parity accumulation and frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      last_q     <= 1'b0;
      exp_q      <= 1'b0;
      frame_open <= 1'b0;
      parity     <= 1'b0;
      word_cnt   <= '0;
    end else begin
      if (accept) begin
        shreg      <= in_data;
        last_q     <= in_last;
        exp_q      <= in_exp_par;
        bit_cnt    <= '0;
        frame_open <= 1'b1;
        if (!frame_open) begin
          parity   <= 1'b0;
          word_cnt <= WCNT_W'(1);
        end else if (word_cnt != '1) begin
          word_cnt <= word_cnt + WCNT_W'(1);
        end
      end
      if (shift_en) begin
        parity  <= parity ^ shreg[0];
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (res_done) begin
        frame_open <= 1'b0;
        word_cnt   <= '0;
        parity     <= 1'b0;
      end
    end
  end

  // Result capture and saturating error statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      res_err    <= 1'b0;
      res_parity <= 1'b0;
      res_words  <= '0;
      err_cnt    <= '0;
    end else if (check_en) begin
      res_err    <= frame_err;
      res_parity <= parity;
      res_words  <= word_cnt;
      if (frame_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Scoreboard bench for parity_frame_ctrl: a word-level parity model pushes
// expected frame results, which are popped and compared when res_valid appears.
module tb_parity_frame_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_exp_par;
  logic              cur_odd;
  logic              res_valid;
  logic              res_ready;
  logic              res_err;
  logic              res_parity;
  logic [7:0]        res_words;
  logic [CNT_W-1:0]  err_cnt;

  parity_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_exp_par (in_exp_par),
    .cur_odd    (cur_odd),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_err    (res_err),
    .res_parity (res_parity),
    .res_words  (res_words),
    .err_cnt    (err_cnt)
  );

  typedef struct packed {
    logic       err;
    logic       par;
    logic [7:0] words;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   passed = 0;
  logic m_par = 1'b0;
  int   m_words = 0;
  bit   m_open = 1'b0;
  int   m_err_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_par     = 1'b0;
    m_words   = 0;
    m_open    = 1'b0;
    m_err_cnt = 0;
    sb.delete();
  endtask

  // Offer one word, wait (bounded) for in_ready, update the model on accept
  task automatic send_word(input logic [DATA_W-1:0] d, input logic l, input logic e,
                           output int waited);
    waited = 0;
    while (in_ready !== 1'b1 && waited < 100) begin
      step();
      waited++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      $display("FAIL send_word_ready: in_ready=%b required 1 within 100 cycles", in_ready);
      return;
    end
    passed++;
    in_valid   = 1'b1;
    in_data    = d;
    in_last    = l;
    in_exp_par = e;
    step();
    in_valid   = 1'b0;
    in_data    = DATA_W'($urandom);
    in_last    = 1'($urandom);
    in_exp_par = 1'($urandom);
    if (!m_open) begin
      m_par   = 1'b0;
      m_words = 0;
      m_open  = 1'b1;
    end
    m_par = m_par ^ (^d);
    if (m_words < 255) m_words++;
    if (l) begin
      sb.push_back('{err: m_par ^ e, par: m_par, words: 8'(m_words)});
      m_open = 1'b0;
    end
  endtask

  // Wait (bounded) for a result, pop the scoreboard and compare, then handshake
  task automatic wait_result(output int lat);
    res_t exp_r;
    res_ready = 1'b1;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    total++;
    if (res_valid !== 1'b1) begin
      $display("FAIL res_valid_timeout: res_valid=%b required 1 within 200 cycles", res_valid);
      return;
    end
    passed++;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL sb_empty: got a result with res_words=%0d but none expected", res_words);
      return;
    end
    passed++;
    exp_r = sb.pop_front();
    if (exp_r.err) m_err_cnt++;
    total++;
    if (res_err !== exp_r.err) $display("FAIL res_err: got %b required %b", res_err, exp_r.err);
    else passed++;
    total++;
    if (res_parity !== exp_r.par) $display("FAIL res_parity: got %b required %b", res_parity, exp_r.par);
    else passed++;
    total++;
    if (res_words !== exp_r.words) $display("FAIL res_words: got %0d required %0d", res_words, exp_r.words);
    else passed++;
    total++;
    if (err_cnt !== CNT_W'(m_err_cnt)) $display("FAIL err_cnt: got %0d required %0d", err_cnt, m_err_cnt);
    else passed++;
    step();
    total++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL post_handshake: res_valid=%b in_ready=%b required 0/1", res_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid   = 1'($urandom);
      in_data    = DATA_W'($urandom);
      in_last    = 1'($urandom);
      in_exp_par = 1'($urandom);
      res_ready  = 1'($urandom);
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b1;
    model_reset();
    total++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || cur_odd !== 1'b0)
      $display("FAIL reset_flags: in_ready=%b res_valid=%b cur_odd=%b required 1/0/0",
               in_ready, res_valid, cur_odd);
    else passed++;
    total++;
    if (res_err !== 1'b0 || res_parity !== 1'b0 || res_words !== 8'd0 || err_cnt !== '0)
      $display("FAIL reset_results: err=%b par=%b words=%0d err_cnt=%0d required 0/0/0/0",
               res_err, res_parity, res_words, err_cnt);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (res_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL reset_idle: res_valid=%b in_ready=%b required 0/1", res_valid, in_ready);
      else passed++;
    end
  endtask

  task automatic test_single_word();
    int w;
    int lat;
    send_word(8'hA5, 1'b1, 1'b0, w);
    wait_result(lat);
    total++;
    if (lat !== 9) $display("FAIL single_latency: res_valid after %0d cycles required 9", lat);
    else passed++;
  endtask

  task automatic test_two_word_mismatch();
    int w;
    int lat;
    send_word(8'h01, 1'b0, 1'b0, w);
    send_word(8'h03, 1'b1, 1'b0, w);
    total++;
    if (w !== 8) $display("FAIL two_word_accept: second word waited %0d cycles required 8", w);
    else passed++;
    wait_result(lat);
  endtask

  task automatic test_cur_odd();
    int w;
    int lat;
    send_word(8'h80, 1'b0, 1'b0, w);
    for (int i = 1; i <= 8; i++) begin
      total++;
      if (cur_odd !== 1'b0) $display("FAIL cur_odd_low: T+%0d cur_odd=%b required 0", i, cur_odd);
      else passed++;
      step();
    end
    total++;
    if (cur_odd !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL cur_odd_high: cur_odd=%b in_ready=%b required 1/1", cur_odd, in_ready);
    else passed++;
    send_word(8'h00, 1'b1, 1'b1, w);
    wait_result(lat);
  endtask

  task automatic test_backpressure();
    int   w;
    int   n;
    res_t exp_r;
    res_ready = 1'b0;
    send_word(8'h07, 1'b1, 1'b0, w);
    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total++;
    if (res_valid !== 1'b1 || sb.size() == 0) begin
      $display("FAIL bp_result: res_valid=%b queued=%0d required 1/1", res_valid, sb.size());
      return;
    end
    passed++;
    exp_r = sb.pop_front();
    if (exp_r.err) m_err_cnt++;
    in_valid   = 1'b1;
    in_data    = 8'h3C;
    in_last    = 1'b1;
    in_exp_par = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (res_valid !== 1'b1 || in_ready !== 1'b0 || res_err !== exp_r.err ||
          res_parity !== exp_r.par || res_words !== exp_r.words || err_cnt !== CNT_W'(m_err_cnt))
        $display("FAIL bp_hold: valid=%b ready=%b err=%b par=%b words=%0d cnt=%0d required 1/0/%b/%b/%0d/%0d",
                 res_valid, in_ready, res_err, res_parity, res_words, err_cnt,
                 exp_r.err, exp_r.par, exp_r.words, m_err_cnt);
      else passed++;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    step();
    total++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0 || cur_odd !== 1'b0)
      $display("FAIL bp_release: in_ready=%b res_valid=%b cur_odd=%b required 1/0/0",
               in_ready, res_valid, cur_odd);
    else passed++;
    step();
    total++;
    if (in_ready !== 1'b1) $display("FAIL bp_no_accept: in_ready=%b required 1", in_ready);
    else passed++;
  endtask

  task automatic test_mid_frame_reset();
    int w;
    int lat;
    send_word(8'hFF, 1'b0, 1'b0, w);
    step();
    step();
    step();
    total++;
    if (cur_odd !== 1'b1) $display("FAIL mid_partial: cur_odd=%b required 1", cur_odd);
    else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    total++;
    if (in_ready !== 1'b1 || cur_odd !== 1'b0 || err_cnt !== '0 || res_valid !== 1'b0)
      $display("FAIL mid_reset: in_ready=%b cur_odd=%b err_cnt=%0d res_valid=%b required 1/0/0/0",
               in_ready, cur_odd, err_cnt, res_valid);
    else passed++;
    send_word(8'h00, 1'b1, 1'b0, w);
    wait_result(lat);
  endtask

  task automatic test_back_to_back();
    int w;
    int lat;
    int nw;
    for (int f = 0; f < 8; f++) begin
      nw = int'($urandom_range(1, 4));
      for (int k = 0; k < nw; k++) begin
        send_word(DATA_W'($urandom), (k == nw - 1), 1'($urandom), w);
      end
      wait_result(lat);
    end
  endtask

  task automatic test_word_saturation();
    int w;
    int lat;
    for (int k = 0; k < 300; k++) begin
      send_word(DATA_W'($urandom), (k == 299), 1'($urandom), w);
    end
    wait_result(lat);
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    in_exp_par = 1'b0;
    res_ready  = 1'b0;
    test_reset();
    test_single_word();
    test_two_word_mismatch();
    test_cur_odd();
    test_backpressure();
    test_mid_frame_reset();
    test_back_to_back();
    test_word_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
